select_scheduler: RTL and testbench

Packet-granular dispatcher that drives the `select` ready/valid channel of the AXI4-Stream demultiplexer and picks which output receives each packet. Outputs are chosen round-robin among those that are enabled and have a free downstream slot, tracked by per-output credit counters. Sinks return credits one at a time. Credits are consumed on each `select` handshake, which the demultiplexer completes on the `tlast` beat of a packet.

---
 rtl/select_scheduler.sv | 102 ++++++++++
 tb/tb_select_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_scheduler.sv
// select_scheduler: round-robin, credit-gated packet dispatcher for the demux select channel (optional SELECT_SCHEDULER_STATS_EN adds pkt_count)
module select_scheduler #(
  parameter int NUM_STREAMS = 4,
  parameter int MAX_CREDITS = 8,
  localparam int CW = $clog2(MAX_CREDITS + 1),
  localparam int IW = $clog2(NUM_STREAMS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_STREAMS-1:0]    out_enable,
  input  logic [NUM_STREAMS-1:0]    credit_return,
  output logic                      select_valid,
  input  logic                      select_ready,
  output logic [IW-1:0]             select_data,
  output logic [NUM_STREAMS*CW-1:0] credits,
  output logic                      credit_overflow,
  output logic                      busy
`ifdef SELECT_SCHEDULER_STATS_EN
  ,
  output logic [NUM_STREAMS*32-1:0] pkt_count
`endif
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] data_q, data_d, ptr_q, ptr_d, start, win;
  logic [CW-1:0] cred_q [NUM_STREAMS];
  logic [CW-1:0] cred_d [NUM_STREAMS];
  logic ovf_q, ovf_d, hs, found;
  logic [NUM_STREAMS-1:0] consume, elig;
  // credit bookkeeping, round-robin search and offer state; after a handshake the search sees post-consume credits
  always_comb begin
    hs = state_q == OFFER && select_ready;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      consume[i] = hs && data_q == IW'(i);
      cred_d[i] = cred_q[i] - CW'(consume[i]) + CW'(credit_return[i]);
      if (credit_return[i] && !consume[i] && cred_q[i] == CW'(MAX_CREDITS)) begin
        cred_d[i] = cred_q[i];
        ovf_d = 1'b1;
      end
      elig[i] = out_enable[i] && (hs ? cred_d[i] : cred_q[i]) != '0;
    end
    start = hs ? (data_q == IW'(NUM_STREAMS - 1) ? '0 : data_q + IW'(1)) : ptr_q;
    found = 1'b0;
    win = '0;
    for (int j = NUM_STREAMS - 1; j >= 0; j--) begin
      if (elig[(int'(start) + j) % NUM_STREAMS]) begin
        found = 1'b1;
        win = IW'((int'(start) + j) % NUM_STREAMS);
      end
    end
    ptr_d = hs ? start : ptr_q;
    state_d = state_q;
    data_d = data_q;
    if (state_q == IDLE || hs) begin
      state_d = (enable && found) ? OFFER : IDLE;
      data_d = (enable && found) ? win : data_q;
    end
  end
  // state, offer and credit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_STREAMS; i++) cred_q[i] <= CW'(MAX_CREDITS);
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_STREAMS; i++) cred_q[i] <= cred_d[i];
    end
  end
  // flatten credit counters onto the output bus
  always_comb begin
    credits = '0;
    for (int i = 0; i < NUM_STREAMS; i++) credits[i*CW +: CW] = cred_q[i];
  end
  assign select_valid = state_q == OFFER;
  assign busy = state_q == OFFER;
  assign select_data = data_q;
  assign credit_overflow = ovf_q;
`ifdef SELECT_SCHEDULER_STATS_EN
  logic [31:0] pkt_q [NUM_STREAMS];
  logic [31:0] pkt_d [NUM_STREAMS];
  // per-output handshake counters, wrapping at 2^32
  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      pkt_d[i] = pkt_q[i] + 32'(consume[i]);
      pkt_count[i*32 +: 32] = pkt_q[i];
    end
  end
  // statistics registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_STREAMS; i++) pkt_q[i] <= rst ? '0 : pkt_d[i];
  end
`endif
endmodule

// File: tb/tb_select_scheduler.sv
// tb_select_scheduler: randomized and directed checks of select_scheduler against a behavioural model
module tb_select_scheduler;
  logic clk = 0, rst = 1, en = 0, rdy = 0;
  logic [3:0] oe = 0, ret = 0;
  logic valid, busy, ovf;
  logic [1:0] data;
  logic [15:0] credits;
  logic [127:0] pkt;
  int errs = 0, checks = 0;
  bit mv, movf;
  int md, mp;
  int mc [4];
  int mpk [4];

  select_scheduler dut (
    .clk(clk), .rst(rst), .enable(en), .out_enable(oe), .credit_return(ret),
    .select_valid(valid), .select_ready(rdy), .select_data(data),
    .credits(credits), .credit_overflow(ovf), .busy(busy)
`ifdef SELECT_SCHEDULER_STATS_EN
    , .pkt_count(pkt)
`endif
  );

`ifndef SELECT_SCHEDULER_STATS_EN
  assign pkt = '0;
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] pk_cred();
    for (int i = 0; i < 4; i++) pk_cred[i*4 +: 4] = 4'(mc[i]);
  endfunction

  function automatic logic [127:0] pk_pkt();
`ifdef SELECT_SCHEDULER_STATS_EN
    for (int i = 0; i < 4; i++) pk_pkt[i*32 +: 32] = 32'(mpk[i]);
`else
    pk_pkt = '0;
`endif
  endfunction

  // one packet per handshake, credits bounded by 8, next winner = first eligible from last grant + 1
  task automatic mdl();
    int nc [4];
    int w;
    bit hs;
    if (rst) begin
      mv = 0; md = 0; mp = 0; movf = 0;
      for (int i = 0; i < 4; i++) begin mc[i] = 8; mpk[i] = 0; end
      return;
    end
    hs = mv && rdy;
    for (int i = 0; i < 4; i++) begin
      nc[i] = mc[i] - ((hs && md == i) ? 1 : 0) + (ret[i] ? 1 : 0);
      if (nc[i] > 8) begin nc[i] = 8; movf = 1; end
    end
    if (hs) begin mpk[md]++; mp = (md + 1) % 4; end
    if (!mv || hs) begin
      w = -1;
      for (int j = 0; j < 4; j++)
        if (w < 0 && oe[(mp + j) % 4] && (hs ? nc[(mp + j) % 4] : mc[(mp + j) % 4]) > 0) w = (mp + j) % 4;
      mv = en && w >= 0;
      if (mv) md = w;
    end
    for (int i = 0; i < 4; i++) mc[i] = nc[i];
  endtask

  task automatic tick();
    @(posedge clk);
    mdl();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; rdy = 0; oe = 0; ret = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; oe = 4'hf; rdy = 1; ret = 4'hf;
    tick();
    rst = 0; ret = 0; en = 0;
    checks++;
    if ({valid, busy, data, ovf} !== 5'b0)
      begin errs++; $display("FAIL reset_ctl: got v=%b b=%b d=%0d o=%b want all 0", valid, busy, data, ovf); end
    checks++;
    if (credits !== 16'h8888) begin errs++; $display("FAIL reset_cred: got %h want 8888", credits); end
    checks++;
    if (pkt !== pk_pkt() || pkt !== 128'b0) begin errs++; $display("FAIL reset_pkt: got %h want 0", pkt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1; oe = 4'hf; rdy = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== 2'(i % 4))
        begin errs++; $display("FAIL rr_seq%0d: got v=%b d=%0d want v=1 d=%0d", i, valid, data, i % 4); end
      checks++;
      if (credits !== pk_cred())
        begin errs++; $display("FAIL rr_cred%0d: got %h want %h", i, credits, pk_cred()); end
      tick();
    end
  endtask

  task automatic test_exhaust();
    int n = 0;
    do_reset();
    en = 1; oe = 4'hf; rdy = 1;
    for (int c = 0; c < 100; c++) begin
      if (valid && rdy) n++;
      tick();
      checks++;
      if (valid !== mv || data !== 2'(md))
        begin errs++; $display("FAIL exh_offer: got v=%b d=%0d want v=%b d=%0d", valid, data, mv, md); end
      if (!valid && c > 0) break;
    end
    checks++;
    if (n != 32) begin errs++; $display("FAIL exh_count: got %0d handshakes want 32", n); end
    checks++;
    if (credits !== 16'h0 || valid !== 1'b0)
      begin errs++; $display("FAIL exh_empty: got c=%h v=%b want c=0000 v=0", credits, valid); end
    ret = 4'b0100;
    tick();
    ret = 0;
    checks++;
    if (credits !== 16'h0100 || valid !== 1'b0)
      begin errs++; $display("FAIL exh_ret: got c=%h v=%b want c=0100 v=0", credits, valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || data !== 2'd2)
      begin errs++; $display("FAIL exh_offer2: got v=%b d=%0d want v=1 d=2", valid, data); end
    tick();
    checks++;
    if (valid !== 1'b0 || credits !== 16'h0)
      begin errs++; $display("FAIL exh_single: got v=%b c=%h want v=0 c=0000", valid, credits); end
  endtask

  task automatic test_mask();
    do_reset();
    en = 1; oe = 4'b1010; rdy = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== ((i % 2) ? 2'd3 : 2'd1))
        begin errs++; $display("FAIL mask_alt%0d: got v=%b d=%0d want v=1 d=%0d", i, valid, data, (i % 2) ? 3 : 1); end
      tick();
    end
    tick();
    rdy = 0; oe = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || data !== 2'd3)
        begin errs++; $display("FAIL mask_hold%0d: got v=%b d=%0d want v=1 d=3", i, valid, data); end
    end
    rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || data !== 2'd1 || credits !== pk_cred())
        begin errs++; $display("FAIL mask_only1_%0d: got v=%b d=%0d c=%h want v=1 d=1 c=%h", i, valid, data, credits, pk_cred()); end
    end
  endtask

  task automatic test_consume_return();
    do_reset();
    en = 1; oe = 4'b0001; rdy = 1;
    tick();
    for (int c = 0; c < 20 && mc[0] != 1; c++) tick();
    checks++;
    if (credits[3:0] !== 4'd1 || valid !== 1'b1 || data !== 2'd0)
      begin errs++; $display("FAIL cr_setup: got c0=%0d v=%b d=%0d want c0=1 v=1 d=0", credits[3:0], valid, data); end
    ret = 4'b0001;
    tick();
    ret = 0; rdy = 0; en = 0;
    checks++;
    if (credits[3:0] !== 4'd1 || ovf !== 1'b0)
      begin errs++; $display("FAIL cr_same: got c0=%0d o=%b want c0=1 o=0", credits[3:0], ovf); end
    ret = 4'b0010;
    tick();
    ret = 0;
    checks++;
    if (credits[7:4] !== 4'd8 || ovf !== 1'b1)
      begin errs++; $display("FAIL cr_ovf: got c1=%0d o=%b want c1=8 o=1", credits[7:4], ovf); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ovf !== 1'b1) begin errs++; $display("FAIL cr_sticky: got o=%b want 1", ovf); end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (ovf !== 1'b0) begin errs++; $display("FAIL cr_clear: got o=%b want 0", ovf); end
  endtask

  task automatic test_backpressure();
    logic [1:0] d0;
    do_reset();
    en = 1; oe = 4'hf; rdy = 0;
    tick();
    d0 = data;
    checks++;
    if (valid !== 1'b1 || d0 !== 2'd0) begin errs++; $display("FAIL bp_start: got v=%b d=%0d want v=1 d=0", valid, d0); end
    for (int i = 0; i < 5; i++) begin
      en = ~en; ret = 4'($urandom); oe = 4'($urandom);
      tick();
      checks++;
      if (valid !== 1'b1 || data !== d0 || credits !== pk_cred())
        begin errs++; $display("FAIL bp_hold%0d: got v=%b d=%0d c=%h want v=1 d=%0d c=%h", i, valid, data, credits, d0, pk_cred()); end
    end
    ret = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1; oe = 4'b0010; rdy = 1;
    tick();
    for (int c = 0; c < 20 && mc[1] != 3; c++) tick();
    checks++;
    if (credits[7:4] !== 4'd3 || valid !== 1'b1)
      begin errs++; $display("FAIL rm_setup: got c1=%0d v=%b want c1=3 v=1", credits[7:4], valid); end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (valid !== 1'b0 || credits !== 16'h8888 || pkt !== 128'b0)
      begin errs++; $display("FAIL rm_clear: got v=%b c=%h p=%h want v=0 c=8888 p=0", valid, credits, pkt); end
    oe = 4'hf; rdy = 0;
    tick();
    checks++;
    if (valid !== 1'b1 || data !== 2'd0)
      begin errs++; $display("FAIL rm_ptr: got v=%b d=%0d want v=1 d=0", valid, data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 59) == 0;
      en = $urandom_range(0, 3) != 0;
      oe = 4'($urandom);
      rdy = $urandom_range(0, 2) != 0;
      for (int i = 0; i < 4; i++) ret[i] = $urandom_range(0, 5) == 0;
      tick();
      checks++;
      if ({valid, busy, data, credits, ovf} !== {mv, mv, 2'(md), pk_cred(), movf} || pkt !== pk_pkt())
        begin errs++; $display("FAIL rand%0d: got v=%b b=%b d=%0d c=%h o=%b want v=%b d=%0d c=%h o=%b", c, valid, busy, data, credits, ovf, mv, md, pk_cred(), movf); end
    end
    rst = 0; ret = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_exhaust();
    test_mask();
    test_consume_return();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
